codec_config_sequencer: RTL
===========================

Name: codec_config_sequencer

Overview:
Owns the I2C link to the WM8731 audio codec and schedules all codec register writes over it. After reset, or on request, it walks a fixed init table and hands each 16-bit command word to a single-transaction I2C engine. It retries NACKed writes and inserts settle gaps between commands. After init it arbitrates runtime writes from game logic (volume/mute) onto the same engine.

Parameters:
DEV_ADDR, 7'h1A, codec 7-bit I2C address driven on i2c_addr.
NUM_CMDS, 7, init table length; entries 0..6 = 16'h1E00, 16'h0C0F, 16'h0E02, 16'h1000, 16'h0812, 16'h0A00, 16'h1201.
GAP_CYCLES, 16, idle clocks between consecutive transactions (min 1).
RESET_WAIT, 1024, extra idle clocks after the table entry 16'h1E00 (codec soft reset) completes.
MAX_RETRY, 3, re-issues allowed per command after the first NACK.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: (re)run init table; ignored unless state is IDLE, DONE or ERROR
cmd_valid  out  1  command presented to I2C engine
cmd_ready  in  1  engine accepts command (transfer when cmd_valid & cmd_ready)
i2c_addr  out  7  constant DEV_ADDR
cmd_word  out  16  {reg[6:0], data[8:0]} for the codec
xfer_done  in  1  one-cycle pulse: engine finished the transaction
xfer_nack  in  1  sampled with xfer_done: 1 = codec did not acknowledge
wr_valid  in  1  runtime write request
wr_word  in  16  runtime command word
wr_ready  out  1  runtime write accepted this cycle
init_done  out  1  table completed successfully; held until next start or rst
init_error  out  1  a command exhausted retries; held until next start or rst
busy  out  1  high in every state except IDLE, DONE, ERROR
cmd_index  out  3  index of table entry in flight (debug)

Behaviour:
- Reset (async, rst=1): state IDLE; cmd_valid=0, cmd_word=0, wr_ready=0, init_done=0, init_error=0, busy=0, cmd_index=0, retry and gap counters 0. rst asserted mid-transaction abandons it immediately; the engine is reset by the same rst.
- Auto-start: the first clock after rst deasserts behaves as a start pulse.
- States: IDLE -> ISSUE (start): cmd_word<=table[cmd_index], cmd_valid=1, cmd_word held stable until the transfer.
- ISSUE -> WAIT on the cmd_valid&cmd_ready cycle; cmd_valid drops the next cycle.
- WAIT: on xfer_done with nack=0 -> GAP, retry count cleared. With nack=1 and retries<MAX_RETRY -> GAP, retries+1, same index. With nack=1 and retries==MAX_RETRY -> ERROR.
- GAP: count GAP_CYCLES clocks (plus RESET_WAIT if the completed word was 16'h1E00 and acked). Then, if index advanced past NUM_CMDS-1 -> DONE, else ISSUE with next/same index. The index increments only on ack.
- DONE: init_done=1. ERROR: init_error=1, cmd_index frozen at the failing entry. Both clear on entering ISSUE via start.
- Runtime writes: serviced only in DONE. wr_ready pulses one cycle when wr_valid=1 and state=DONE. The word is latched and goes DONE -> RT_ISSUE -> RT_WAIT -> RT_GAP -> DONE with the same retry rules; exhaustion -> ERROR, init_done cleared.
- A runtime write in any other state is held off (wr_ready=0); the requester keeps wr_valid.
- Simultaneous start and wr_valid in DONE: start wins; wr_ready stays 0.
- xfer_done outside WAIT/RT_WAIT is ignored. cmd_ready is ignored when cmd_valid=0.
- start while busy is ignored (no restart, no flag change).
- Counter widths are sized for the largest of GAP_CYCLES+RESET_WAIT and MAX_RETRY. The gap counter must not wrap.

Test Plan:
1. Release rst, engine acks all -> 7 transfers with words 1E00,0C0F,0E02,1000,0812,0A00,1201 in order. Gap ≥16 clocks between them, ≥1040 after 1E00. init_done=1, busy=0.
2. Entry 2 NACKed twice then acked -> 0E02 issued 3 times, sequence completes, init_done=1, init_error=0.
3. Entry 4 NACKed 4 times -> 0812 issued exactly 4 times, ERROR, init_error=1, cmd_index=4. Then start -> table restarts at 1E00, init_error clears.
4. In DONE, wr_valid with 16'h0E7F, engine acks -> wr_ready one-cycle pulse, one transfer of 0E7F, return to DONE. Same request during init -> wr_ready=0 until DONE.
5. cmd_ready delayed 5 cycles -> cmd_valid and cmd_word stable throughout. start pulse during WAIT -> no effect.
6. rst asserted during WAIT of entry 3 -> all outputs at reset values that cycle; after release, the sequence restarts at entry 0.

Source files
------------

// File: rtl/codec_config_sequencer.sv
// codec_config_sequencer: walks the WM8731 init table over a single-transaction I2C engine,
// retrying NACKed writes and spacing commands, then arbitrates runtime writes in DONE.
module codec_config_sequencer #(
    parameter logic [6:0] DEV_ADDR   = 7'h1A,
    parameter int         NUM_CMDS   = 7,
    parameter int         GAP_CYCLES = 16,
    parameter int         RESET_WAIT = 1024,
    parameter int         MAX_RETRY  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [6:0]  i2c_addr,
    output logic [15:0] cmd_word,
    input  logic        xfer_done,
    input  logic        xfer_nack,
    input  logic        wr_valid,
    input  logic [15:0] wr_word,
    output logic        wr_ready,
    output logic        init_done,
    output logic        init_error,
    output logic        busy,
    output logic [2:0]  cmd_index
);
    localparam int MAX_CNT = (GAP_CYCLES + RESET_WAIT > MAX_RETRY) ? GAP_CYCLES + RESET_WAIT : MAX_RETRY;
    localparam int CW = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] RST_LD = CW'(GAP_CYCLES + RESET_WAIT - 1);
    localparam logic [CW-1:0] RETRY_MAX = CW'(MAX_RETRY);
    localparam logic [15:0] SOFT_RESET = 16'h1E00;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_ISSUE    = 4'd1;
    localparam logic [3:0] S_WAIT     = 4'd2;
    localparam logic [3:0] S_GAP      = 4'd3;
    localparam logic [3:0] S_DONE     = 4'd4;
    localparam logic [3:0] S_ERROR    = 4'd5;
    localparam logic [3:0] S_RT_ISSUE = 4'd6;
    localparam logic [3:0] S_RT_WAIT  = 4'd7;
    localparam logic [3:0] S_RT_GAP   = 4'd8;

    logic [3:0]    state;
    logic [CW-1:0] gap_cnt;
    logic [CW-1:0] retry;
    logic          auto_start;
    logic          can_start;
    logic          rt;

    function automatic logic [15:0] init_word(input logic [2:0] i);
        case (i)
            3'd0:    init_word = 16'h1E00;
            3'd1:    init_word = 16'h0C0F;
            3'd2:    init_word = 16'h0E02;
            3'd3:    init_word = 16'h1000;
            3'd4:    init_word = 16'h0812;
            3'd5:    init_word = 16'h0A00;
            3'd6:    init_word = 16'h1201;
            default: init_word = 16'h0000;
        endcase
    endfunction

    assign i2c_addr  = DEV_ADDR;
    assign cmd_valid = state == S_ISSUE || state == S_RT_ISSUE;
    assign busy      = !(state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign can_start = !busy && (start || auto_start);
    assign wr_ready  = state == S_DONE && wr_valid && !start;
    assign rt        = state == S_RT_WAIT;

    // auto_start makes the first clock after reset release act as a start pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            gap_cnt    <= '0;
            retry      <= '0;
            auto_start <= 1'b1;
            cmd_word   <= '0;
            cmd_index  <= '0;
            init_done  <= 1'b0;
            init_error <= 1'b0;
        end else begin
            auto_start <= 1'b0;
            if (can_start) begin
                state      <= S_ISSUE;
                cmd_index  <= '0;
                cmd_word   <= init_word(3'd0);
                retry      <= '0;
                init_done  <= 1'b0;
                init_error <= 1'b0;
            end else begin
                case (state)
                    S_DONE: if (wr_valid) begin
                        state    <= S_RT_ISSUE;
                        cmd_word <= wr_word;
                        retry    <= '0;
                    end
                    S_ISSUE:    if (cmd_ready) state <= S_WAIT;
                    S_RT_ISSUE: if (cmd_ready) state <= S_RT_WAIT;
                    S_WAIT, S_RT_WAIT: if (xfer_done) begin
                        if (!xfer_nack) begin
                            state   <= rt ? S_RT_GAP : S_GAP;
                            retry   <= '0;
                            gap_cnt <= cmd_word == SOFT_RESET ? RST_LD : GAP_LD;
                            if (!rt) cmd_index <= cmd_index + 3'd1;
                        end else if (retry != RETRY_MAX) begin
                            state   <= rt ? S_RT_GAP : S_GAP;
                            retry   <= retry + 1'b1;
                            gap_cnt <= GAP_LD;
                        end else begin
                            state      <= S_ERROR;
                            init_error <= 1'b1;
                            init_done  <= 1'b0;
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                        else if (cmd_index == 3'(NUM_CMDS)) begin
                            state     <= S_DONE;
                            init_done <= 1'b1;
                        end else begin
                            state    <= S_ISSUE;
                            cmd_word <= init_word(cmd_index);
                        end
                    end
                    // a nonzero retry count here means the last runtime attempt was NACKed
                    S_RT_GAP: begin
                        if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                        else state <= retry == '0 ? S_DONE : S_RT_ISSUE;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
